// File: rtl/fmul_pipe.sv
// fmul_pipe: parametrised floating-point multiplier with special-value handling, rounding and IEEE-style flags.
// Latency: 3 register stages (S1 unpack/partial products, S2 product/exponent, S3 normalise/round/output); 1 op per cycle.
// Backpressure: stall = out_valid & ~out_ready freezes every stage; in_ready = ~stall (combinational).
module fmul_pipe #(
  parameter int EW    = 8,
  parameter int MW    = 23,
  parameter int ROUND = 1,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EW+MW:0]   x1,
  input  logic [EW+MW:0]   x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EW+MW:0]   y,
  output logic [TAG_W-1:0] out_tag,
  output logic             ovf,
  output logic             udf,
  output logic             inv,
  output logic             nx
);

  localparam int W  = EW + MW + 1;
  localparam int SW = MW + 1;        // significand width including hidden 1
  localparam int LW = SW / 2;        // low slice of operand 2 for the split product
  localparam int HW = SW - LW;       // high slice of operand 2
  localparam int PW = 2 * SW;        // full product width
  localparam int XW = EW + 2;        // signed exponent, wide enough to never wrap
  localparam logic [EW-1:0]        EXP_ONES = '1;
  localparam logic signed [XW-1:0] BIAS     = XW'((1 << (EW - 1)) - 1);
  localparam logic signed [XW-1:0] EMAX     = XW'((1 << EW) - 1);

  // The whole pipe advances together unless the output is being held.
  logic adv;
  assign adv      = ~(out_valid & ~out_ready);
  assign in_ready = adv;

  // Operand classification; exp=0 covers both zero and flushed subnormals.
  logic [EW-1:0] e_a, e_b;
  logic [MW-1:0] m_a, m_b;
  logic          zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  logic [SW-1:0] sig_a, sig_b;
  assign e_a    = x1[W-2:MW];
  assign e_b    = x2[W-2:MW];
  assign m_a    = x1[MW-1:0];
  assign m_b    = x2[MW-1:0];
  assign zero_a = (e_a == '0);
  assign zero_b = (e_b == '0);
  assign inf_a  = (e_a == EXP_ONES) && (m_a == '0);
  assign inf_b  = (e_b == EXP_ONES) && (m_b == '0);
  assign nan_a  = (e_a == EXP_ONES) && (m_a != '0);
  assign nan_b  = (e_b == EXP_ONES) && (m_b != '0);
  assign sig_a  = {1'b1, m_a};
  assign sig_b  = {1'b1, m_b};

  // Stage 1 registers
  logic             v1_q, v1_d, s1_q, s1_d;
  logic             nan1_q, nan1_d, inf1_q, inf1_d, zero1_q, zero1_d;
  logic [EW-1:0]    ea1_q, ea1_d, eb1_q, eb1_d;
  logic [SW+LW-1:0] plo1_q, plo1_d;
  logic [SW+HW-1:0] phi1_q, phi1_d;
  logic [TAG_W-1:0] tag1_q, tag1_d;

  // Stage 2 registers
  logic                 v2_q, v2_d, s2_q, s2_d;
  logic                 nan2_q, nan2_d, inf2_q, inf2_d, zero2_q, zero2_d;
  logic signed [XW-1:0] exp2_q, exp2_d;
  logic [PW-1:0]        prod2_q, prod2_d;
  logic [TAG_W-1:0]     tag2_q, tag2_d;

  // Output registers
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     y_q, y_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             ovf_q, ovf_d, udf_q, udf_d, inv_q, inv_d, nx_q, nx_d;

  // S1: fold classification into a single special-case class and form two partial products.
  always_comb begin
    v1_d    = v1_q;
    s1_d    = s1_q;
    nan1_d  = nan1_q;
    inf1_d  = inf1_q;
    zero1_d = zero1_q;
    ea1_d   = ea1_q;
    eb1_d   = eb1_q;
    plo1_d  = plo1_q;
    phi1_d  = phi1_q;
    tag1_d  = tag1_q;
    if (adv) begin
      v1_d    = in_valid;
      s1_d    = x1[W-1] ^ x2[W-1];
      nan1_d  = nan_a | nan_b | (zero_a & inf_b) | (inf_a & zero_b);
      inf1_d  = inf_a | inf_b;
      zero1_d = zero_a | zero_b;
      ea1_d   = e_a;
      eb1_d   = e_b;
      plo1_d  = {{LW{1'b0}}, sig_a} * {{SW{1'b0}}, sig_b[LW-1:0]};
      phi1_d  = {{HW{1'b0}}, sig_a} * {{SW{1'b0}}, sig_b[SW-1:LW]};
      tag1_d  = in_tag;
    end
  end

  // S2: combine partial products into the full product and form the biased exponent sum.
  always_comb begin
    v2_d    = v2_q;
    s2_d    = s2_q;
    nan2_d  = nan2_q;
    inf2_d  = inf2_q;
    zero2_d = zero2_q;
    exp2_d  = exp2_q;
    prod2_d = prod2_q;
    tag2_d  = tag2_q;
    if (adv) begin
      v2_d    = v1_q;
      s2_d    = s1_q;
      nan2_d  = nan1_q;
      inf2_d  = inf1_q;
      zero2_d = zero1_q;
      exp2_d  = $signed({2'b00, ea1_q}) + $signed({2'b00, eb1_q}) - BIAS;
      prod2_d = ({{LW{1'b0}}, phi1_q} << LW) + {{HW{1'b0}}, plo1_q};
      tag2_d  = tag1_q;
    end
  end

  // Normalise and round the product of two [1,2) significands.
  logic [PW-1:0]        norm;
  logic [SW-1:0]        sig_n;
  logic                 guard, sticky, inc, carry;
  logic [SW:0]          sig_r;
  logic [MW-1:0]        mant_r;
  logic signed [XW-1:0] exp_r;

  // S3: rounding datapath, then special/overflow/underflow result select into the output registers.
  always_comb begin
    norm   = prod2_q[PW-1] ? prod2_q : (prod2_q << 1);
    sig_n  = norm[PW-1:MW+1];
    guard  = norm[MW];
    sticky = |norm[MW-1:0];
    inc    = (ROUND != 0) && guard && (sticky || sig_n[0]);
    sig_r  = {1'b0, sig_n} + {{SW{1'b0}}, inc};
    carry  = sig_r[SW];
    mant_r = carry ? sig_r[MW:1] : sig_r[MW-1:0];
    exp_r  = exp2_q + $signed({{(XW-1){1'b0}}, prod2_q[PW-1]})
                    + $signed({{(XW-1){1'b0}}, carry});

    out_valid_d = out_valid_q;
    y_d         = y_q;
    out_tag_d   = out_tag_q;
    ovf_d       = ovf_q;
    udf_d       = udf_q;
    inv_d       = inv_q;
    nx_d        = nx_q;
    if (adv) begin
      out_valid_d = v2_q;
      out_tag_d   = tag2_q;
      ovf_d       = 1'b0;
      udf_d       = 1'b0;
      inv_d       = 1'b0;
      nx_d        = 1'b0;
      if (nan2_q) begin
        y_d   = {1'b0, EXP_ONES, 1'b1, {(MW-1){1'b0}}};
        inv_d = 1'b1;
      end else if (inf2_q) begin
        y_d = {s2_q, EXP_ONES, {MW{1'b0}}};
      end else if (zero2_q) begin
        y_d = {s2_q, {EW{1'b0}}, {MW{1'b0}}};
      end else if (exp_r >= EMAX) begin
        y_d   = {s2_q, EXP_ONES, {MW{1'b0}}};
        ovf_d = 1'b1;
        nx_d  = 1'b1;
      end else if (exp_r <= 0) begin
        y_d   = {s2_q, {EW{1'b0}}, {MW{1'b0}}};
        udf_d = 1'b1;
        nx_d  = 1'b1;
      end else begin
        y_d  = {s2_q, exp_r[EW-1:0], mant_r};
        nx_d = guard | sticky;
      end
    end
  end

  // State registers for all three stages; reset empties the pipe and clears the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0; s1_q <= 1'b0; nan1_q <= 1'b0; inf1_q <= 1'b0; zero1_q <= 1'b0;
      ea1_q <= '0; eb1_q <= '0; plo1_q <= '0; phi1_q <= '0; tag1_q <= '0;
      v2_q <= 1'b0; s2_q <= 1'b0; nan2_q <= 1'b0; inf2_q <= 1'b0; zero2_q <= 1'b0;
      exp2_q <= '0; prod2_q <= '0; tag2_q <= '0;
      out_valid_q <= 1'b0; y_q <= '0; out_tag_q <= '0;
      ovf_q <= 1'b0; udf_q <= 1'b0; inv_q <= 1'b0; nx_q <= 1'b0;
    end else begin
      v1_q <= v1_d; s1_q <= s1_d; nan1_q <= nan1_d; inf1_q <= inf1_d; zero1_q <= zero1_d;
      ea1_q <= ea1_d; eb1_q <= eb1_d; plo1_q <= plo1_d; phi1_q <= phi1_d; tag1_q <= tag1_d;
      v2_q <= v2_d; s2_q <= s2_d; nan2_q <= nan2_d; inf2_q <= inf2_d; zero2_q <= zero2_d;
      exp2_q <= exp2_d; prod2_q <= prod2_d; tag2_q <= tag2_d;
      out_valid_q <= out_valid_d; y_q <= y_d; out_tag_q <= out_tag_d;
      ovf_q <= ovf_d; udf_q <= udf_d; inv_q <= inv_d; nx_q <= nx_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign out_tag   = out_tag_q;
  assign ovf       = ovf_q;
  assign udf       = udf_q;
  assign inv       = inv_q;
  assign nx        = nx_q;

endmodule

// File: tb/tb_fmul_pipe.sv
// tb_fmul_pipe: directed vector table for fmul_pipe (round-to-nearest and truncate instances side by side).
// Latency: results expected three edges after the op is presented with in_ready=1.
// Backpressure: scripted out_ready gaps, reset mid-stream, ordering and hold-stability checks.
module tb_fmul_pipe;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;     // round-to-nearest-even result
    logic [31:0] y_t;   // truncate result
    logic [3:0]  flg;   // {ovf, udf, inv, nx}
  } vec_t;

  localparam int N = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready;
  logic [31:0] x1, x2;
  logic [4:0]  in_tag;
  logic        in_ready, out_valid, ovf, udf, inv, nx;
  logic [31:0] y;
  logic [4:0]  out_tag;
  logic        in_ready_t, out_valid_t, ovf_t, udf_t, inv_t, nx_t;
  logic [31:0] y_t;
  logic [4:0]  out_tag_t;

  fmul_pipe #(.EW(8), .MW(23), .ROUND(1), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .out_tag(out_tag),
    .ovf(ovf), .udf(udf), .inv(inv), .nx(nx)
  );

  fmul_pipe #(.EW(8), .MW(23), .ROUND(0), .TAG_W(5)) dut_t (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_t),
    .x1(x1), .x2(x2), .in_tag(in_tag),
    .out_valid(out_valid_t), .out_ready(out_ready), .y(y_t), .out_tag(out_tag_t),
    .ovf(ovf_t), .udf(udf_t), .inv(inv_t), .nx(nx_t)
  );

  int total = 0;
  int bad   = 0;
  vec_t vt [N];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, want %h", nm, act, req);
    end
  endtask

  logic [3:0]  flags;
  assign flags = {ovf, udf, inv, nx};

  int          ai, ri, k;
  logic        held;
  logic [31:0] hy;
  logic [4:0]  ht;
  logic [3:0]  hf;

  initial begin
    vt[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 32'h40400000, 4'b0000};
    vt[1]  = '{32'h3FC00001, 32'h3FC00001, 32'h40100002, 32'h40100001, 4'b0001};
    vt[2]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 32'h7FC00000, 4'b0010};
    vt[3]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 32'hFF800000, 4'b0000};
    vt[4]  = '{32'h80000000, 32'h3F800000, 32'h80000000, 32'h80000000, 4'b0000};
    vt[5]  = '{32'h7FA00000, 32'h3F800000, 32'h7FC00000, 32'h7FC00000, 4'b0010};
    vt[6]  = '{32'h7F000000, 32'h40000000, 32'h7F800000, 32'h7F800000, 4'b1001};
    vt[7]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 32'h00000000, 4'b0101};
    vt[8]  = '{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 32'h7F7FFFFF, 4'b0000};
    vt[9]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 32'h3FC00001, 4'b0001}; // tie, odd lsb
    vt[10] = '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 32'h3FC00004, 4'b0001}; // tie, even lsb
    vt[11] = '{32'h3F918E00, 32'h3FE12000, 32'h40000000, 32'h3FFFFFFF, 4'b0001}; // rounding carry-out
    vt[12] = '{32'hC0000000, 32'h3FC00000, 32'hC0400000, 32'hC0400000, 4'b0000};
    vt[13] = '{32'h00000001, 32'h40000000, 32'h00000000, 32'h00000000, 4'b0000}; // subnormal flushed
    vt[14] = '{32'hFFC00001, 32'h7F800000, 32'h7FC00000, 32'h7FC00000, 4'b0010};
    vt[15] = '{32'h00800000, 32'h3F800000, 32'h00800000, 32'h00800000, 4'b0000}; // min normal

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    x1 = '0; x2 = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_y", y, 0);
    chk("reset_tag", out_tag, 0);
    chk("reset_flags", flags, 0);
    chk("reset_in_ready", in_ready, 1);

    // Back-to-back stream of every vector; checks latency, throughput and results.
    for (int c = 0; c < N + 4; c++) begin
      @(negedge clk);
      if (c < N) begin
        in_valid = 1'b1; x1 = vt[c].a; x2 = vt[c].b; in_tag = c[4:0];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c < 3 || c >= N + 3) begin
        chk("stream_idle_valid", out_valid, 0);
      end else begin
        k = c - 3;
        chk("stream_valid", out_valid, 1);
        chk("stream_y", y, vt[k].y);
        chk("stream_tag", out_tag, k);
        chk("stream_flags", flags, vt[k].flg);
        chk("stream_trunc_y", y_t, vt[k].y_t);
        chk("stream_trunc_nx", nx_t, vt[k].flg[0]);
      end
    end

    // Backpressure: 8 ops, consumer stalls in cycles 4..6.
    ai = 0; ri = 0; held = 1'b0;
    for (int c = 0; c < 40 && ri < 8; c++) begin
      @(negedge clk);
      out_ready = !(c >= 4 && c <= 6);
      in_valid  = (ai < 8);
      if (ai < 8) begin
        x1 = vt[ai].a; x2 = vt[ai].b; in_tag = ai[4:0];
      end
      #1;
      if (c < 14) chk("bp_in_ready", in_ready, (c >= 4 && c <= 6) ? 1'b0 : 1'b1);
      if (held) begin
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_y", y, hy);
        chk("bp_hold_tag", out_tag, ht);
        chk("bp_hold_flags", flags, hf);
      end
      held = out_valid && !out_ready;
      hy = y; ht = out_tag; hf = flags;
      if (out_valid && out_ready) begin
        chk("bp_order_tag", out_tag, ri);
        chk("bp_y", y, vt[ri].y);
        chk("bp_flags", flags, vt[ri].flg);
        ri++;
      end
      if (in_valid && in_ready) ai++;
    end
    chk("bp_result_count", ri, 8);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("bp_no_duplicate", out_valid, 0);
    end

    // Reset with three ops in flight.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1; x1 = vt[c].a; x2 = vt[c].b; in_tag = 5'(10 + c);
    end
    @(negedge clk);
    x1 = vt[3].a; x2 = vt[3].b; in_tag = 5'd13; out_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_y", y, 0);
    chk("rst_mid_tag", out_tag, 0);
    chk("rst_mid_flags", flags, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("rst_no_stale", out_valid, 0);
    end
    @(negedge clk);
    in_valid = 1'b1; x1 = vt[12].a; x2 = vt[12].b; in_tag = 5'd21;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("post_rst_lat1", out_valid, 0);
    @(negedge clk);
    #1;
    chk("post_rst_lat2", out_valid, 0);
    @(negedge clk);
    #1;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_y", y, vt[12].y);
    chk("post_rst_tag", out_tag, 21);
    chk("post_rst_flags", flags, vt[12].flg);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fmul_pipe.md
Name: fmul_pipe

Overview:
- Parametrised, fully pipelined floating-point multiplier. Next generation of the team's single-precision fmul.
- Generic exponent/mantissa widths, selectable rounding (truncate or round-to-nearest-even), full special-value handling, IEEE-style exception flags.
- Valid/ready handshake with backpressure and a tag passthrough, so it plugs directly into the FPU issue/writeback path.

Parameters:
EW, 8, exponent width in bits
MW, 23, stored mantissa width in bits (hidden 1 not stored)
ROUND, 1, 0 = truncate toward zero, 1 = round to nearest, ties to even
TAG_W, 5, width of opaque tag carried alongside each operation

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operands present on x1/x2/in_tag
in_ready  output  1  block accepts the operation this cycle
x1  input  EW+MW+1  operand 1 {sign, exp, mant}
x2  input  EW+MW+1  operand 2
in_tag  input  TAG_W  tag for the operation
out_valid  output  1  result present on y/out_tag/flags
out_ready  input  1  consumer takes the result this cycle
y  output  EW+MW+1  product
out_tag  output  TAG_W  tag of this result
ovf  output  1  overflow flag, qualified by out_valid
udf  output  1  underflow flag (result flushed to zero)
inv  output  1  invalid flag (NaN operand or 0*inf)
nx  output  1  inexact flag

Behaviour:
- Reset: clk and rst are the only clock and reset; rst is synchronous and active-high. When rst=1 at an edge, all stage valid bits clear, out_valid=0, y=0, out_tag=0, and all four flags=0. In-flight operations are discarded, and none reappear after rst deasserts. in_ready=1 in the cycle after reset.
- Pipeline: 3 register stages, each with its own valid bit.
  - S1: operand unpack and classification; start of significand product.
  - S2: product completion; exponent sum e1+e2-bias, where bias = 2^(EW-1)-1.
  - S3: normalise, round, exception select; output registers.
- Latency: an operation accepted at edge k is on the outputs with out_valid=1 after edge k+3, provided there is no stall. Throughput is 1 per cycle.
- Handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall, and is combinational from out_ready and out_valid.
  - Accept occurs when in_valid & in_ready.
  - During a stall, every stage holds. y/out_tag/flags are stable while out_valid=1 and out_ready=0.
  - Bubbles are not collapsed.
  - A transfer occurs when out_valid & out_ready. Accept and transfer in the same cycle are legal.
  - Order is preserved; no operation is lost or duplicated.
- Classification (per operand):
  - exp=0: zero. Subnormals are flushed to zero.
  - exp=all-ones with mant=0: inf.
  - exp=all-ones with mant!=0: NaN.
- Result sign: s1^s2 for every case except NaN.
- Special results (priority order):
  1. Either operand NaN, or zero*inf: y = canonical qNaN {0, all-ones, 1, zeros}, inv=1.
  2. Either operand inf: y = signed inf, no flags.
  3. Either operand zero: y = signed zero, no flags.
- Normal path:
  - Full (MW+1)x(MW+1) product; no partial-product truncation.
  - If the product MSB is set, shift right by 1 and add 1 to the exponent.
  - Guard bit = first discarded bit; sticky = OR of the remaining discarded bits.
  - ROUND=1: increment when guard & (sticky | lsb). A mantissa carry-out renormalises and adds 1 to the exponent.
  - ROUND=0: discard the bits.
  - nx = guard|sticky.
- Exponent boundaries (evaluated after rounding, on a signed exponent wide enough to avoid wrap, at least EW+2 bits):
  - exp >= all-ones: signed inf, ovf=1, nx=1.
  - exp <= 0: signed zero, udf=1, nx=1.
  - Exactly all-ones-minus-1 is a valid maximum normal.
- Flags are registered with y and are meaningless when out_valid=0. Only one of ovf/udf/inv can be set per result.

Test Plan:
1. x1=0x3FC00000, x2=0x40000000, single accept -> y=0x40400000 exactly 3 cycles later, all flags 0, out_tag equals in_tag.
2. x1=x2=0x3FC00001 -> ROUND=1 gives y=0x40100002, nx=1; ROUND=0 gives y=0x40100001, nx=1.
3. Specials:
   - 0x7F800000*0x00000000 -> 0x7FC00000, inv=1.
   - 0xFF800000*0x40000000 -> 0xFF800000, flags 0.
   - 0x80000000*0x3F800000 -> 0x80000000.
   - 0x7FA00000*0x3F800000 -> 0x7FC00000, inv=1.
4. Boundaries:
   - 0x7F000000*0x40000000 -> 0x7F800000, ovf=1, nx=1.
   - 0x00800000*0x3F000000 -> 0x00000000, udf=1.
   - 0x7F7FFFFF*0x3F800000 -> 0x7F7FFFFF, flags 0.
5. Backpressure: 8 back-to-back ops with tags 0..7, out_ready=0 for cycles 4-6.
   - in_ready must be 0 in exactly those cycles.
   - Outputs are held stable.
   - Results arrive in tag order 0..7, each exactly once and matching the reference model.
6. Reset mid-stream: 3 ops in flight, rst=1 for one cycle -> out_valid=0 next cycle, outputs 0, no stale result after release. A new op then appears with 3-cycle latency.
